// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// Module : cpu_defs_pkg
// Brief  : Sequencer state encoding and opcode/funct constants shared by the
//          multi-cycle control path and the instruction decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_defs_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EXE  = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  function automatic logic is_jr(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_JR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// Module : next_pc_calc
// Brief  : Combinational next-PC selection: PC+4, branch, jump, register jump.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module next_pc_calc
  import cpu_defs_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] target26_i,
  input  logic [31:0] rs_data_i,
  input  logic        zero_i,
  output logic [31:0] new_addr_o
);

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        br_taken;

  assign pc4      = pc_i + 32'd4;
  assign br_tgt   = pc4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
  assign j_tgt    = {pc4[31:28], target26_i, 2'b00};
  assign br_taken = ((opcode_i == OP_BEQ) &&  zero_i) ||
                    ((opcode_i == OP_BNE) && !zero_i);

  always_comb begin
    new_addr_o = pc4;
    if (is_jr(opcode_i, funct_i)) begin
      new_addr_o = rs_data_i;
    end else if ((opcode_i == OP_J) || (opcode_i == OP_JAL)) begin
      new_addr_o = j_tgt;
    end else if (br_taken) begin
      new_addr_o = br_tgt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module : pc_sequencer
// Brief  : Multi-cycle IF/ID/EXE/MEM/WB sequencer owning the PC write path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import cpu_defs_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_data,
  input  logic        zero,
  output logic        PCWre,
  output logic [31:0] new_addr,
  output logic        IRWre,
  output logic        RegWre,
  output logic        MemWre,
  output logic        halted,
  output logic [2:0]  state
);

  state_e state_q;
  state_e state_d;

  logic pcwre_d;
  logic irwre_d;
  logic regwre_d;
  logic memwre_d;

  logic is_jump;
  logic is_branch;
  logic is_mem;

  assign is_jump   = is_jr(opcode, funct) || (opcode == OP_J) || (opcode == OP_JAL);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_mem    = (opcode == OP_LW) || (opcode == OP_SW);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Each instruction asserts PCWre exactly once, in whichever state retires it.
  always_comb begin
    state_d  = state_q;
    pcwre_d  = 1'b0;
    irwre_d  = 1'b0;
    regwre_d = 1'b0;
    memwre_d = 1'b0;
    case (state_q)
      ST_IF: begin
        irwre_d = 1'b1;
        state_d = ST_ID;
      end
      ST_ID: begin
        if (is_jump) begin
          pcwre_d  = 1'b1;
          regwre_d = (opcode == OP_JAL);
          state_d  = ST_IF;
        end else if (opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        if (is_branch) begin
          pcwre_d = 1'b1;
          state_d = ST_IF;
        end else if (is_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (opcode == OP_SW) begin
          pcwre_d  = 1'b1;
          memwre_d = 1'b1;
          state_d  = ST_IF;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        pcwre_d  = 1'b1;
        regwre_d = 1'b1;
        state_d  = ST_IF;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IF;
      end
    endcase
  end

  // Reset gates the enables so nothing is written while the core is held.
  assign PCWre  = pcwre_d  & Reset;
  assign IRWre  = irwre_d  & Reset;
  assign RegWre = regwre_d & Reset;
  assign MemWre = memwre_d & Reset;
  assign halted = (state_q == ST_HALT);
  assign state  = state_q;

  next_pc_calc u_next_pc_calc (
    .pc_i       (PC),
    .opcode_i   (opcode),
    .funct_i    (funct),
    .imm16_i    (imm16),
    .target26_i (target26),
    .rs_data_i  (rs_data),
    .zero_i     (zero),
    .new_addr_o (new_addr)
  );

endmodule

`default_nettype wire
